// File: rtl/clock_step_controller_if.sv
// Command channel into the clock step controller: valid/ready with an opcode and an argument.
interface clock_step_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [CNT_WIDTH-1:0] cmd_arg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_arg,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_arg,
        output cmd_ready
    );
endinterface

// File: rtl/clock_step_controller.sv
// Generates one-cycle clk_en pulses: free run, halt, or a counted step, with period div+1.
// clk_en is a function of registered state only; commands are refused while a step is in flight.
module clock_step_controller #(
    parameter int CNT_WIDTH = 16,
    parameter int DIV_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    clock_step_controller_if.slave cmd,
    output logic                  clk_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  tick_count
);

    localparam logic [1:0] OP_HALT    = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_STEP    = 2'b10;
    localparam logic [1:0] OP_SET_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP
    } state_e;

    state_e               state, state_n;
    logic [DIV_WIDTH-1:0] div, div_n;
    logic [DIV_WIDTH-1:0] div_cnt, div_cnt_n;
    logic [DIV_WIDTH-1:0] arg_div;
    logic [CNT_WIDTH-1:0] remaining, remaining_n;
    logic                 done_n;
    logic                 ticking;
    logic                 accept;

    assign arg_div      = DIV_WIDTH'(cmd.cmd_arg);
    assign ticking      = (state == S_RUN) || (state == S_STEP);
    assign clk_en       = ticking && (div_cnt == div);
    assign busy         = (state != S_IDLE);
    assign cmd.cmd_ready = (state != S_STEP);
    assign accept       = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_n     = state;
        div_n       = div;
        div_cnt_n   = '0;
        remaining_n = remaining;
        done_n      = 1'b0;

        if (ticking && !clk_en) begin
            div_cnt_n = div_cnt + DIV_WIDTH'(1);
        end

        if ((state == S_STEP) && clk_en) begin
            remaining_n = remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
            end
        end

        // Only IDLE and RUN reach here, since STEP holds cmd_ready low.
        if (accept) begin
            case (cmd.cmd_op)
                OP_HALT: begin
                    if (state == S_RUN) begin
                        state_n = S_IDLE;
                    end
                end
                OP_RUN: begin
                    // A repeated RUN must not disturb the running phase.
                    if (state == S_IDLE) begin
                        state_n   = S_RUN;
                        div_cnt_n = '0;
                    end
                end
                OP_STEP: begin
                    if (cmd.cmd_arg != '0) begin
                        state_n     = S_STEP;
                        remaining_n = cmd.cmd_arg;
                        div_cnt_n   = '0;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
                OP_SET_DIV: begin
                    div_n     = arg_div;
                    div_cnt_n = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            div        <= '0;
            div_cnt    <= '0;
            remaining  <= '0;
            done       <= 1'b0;
            tick_count <= '0;
        end else begin
            state     <= state_n;
            div       <= div_n;
            div_cnt   <= div_cnt_n;
            remaining <= remaining_n;
            done      <= done_n;
            if (clk_en) begin
                tick_count <= tick_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
